imem_wb_loader: RTL and testbench

- Wishbone slave that loads and reads back the 32x256 instruction SRAM and arbitrates the SRAM port between itself and the core.
- Sits directly upstream of the SRAM macro. It replaces the logic-analyzer load path (din, csb and address from LA pins) with a register-mapped window on the Caravel Wishbone bus.
- Drives the core's init_en and reset, so firmware holds the core while the SRAM is programmed and then releases it.

---
 rtl/imem_wb_pkg.sv | 20 ++
 rtl/imem_sram_mux.sv | 37 +++
 rtl/imem_wb_loader.sv | 187 ++++++++++++++++++
 tb/tb_imem_wb_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_wb_pkg.sv
// Shared constants and FSM encoding for the instruction-SRAM Wishbone loader.
package imem_wb_pkg;

    localparam logic [11:0] OFF_CTRL    = 12'h400;
    localparam logic [11:0] OFF_STATUS  = 12'h404;
    localparam logic [11:0] OFF_MEM_MAX = 12'h3FC;

    localparam int unsigned CTRL_LOAD_BIT = 0;
    localparam int unsigned CTRL_RST_BIT  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_CAP,
        S_ACK
    } state_e;

endpackage

// File: rtl/imem_sram_mux.sv
// SRAM port ownership mux: loader while load_mode is set, otherwise the core.
module imem_sram_mux #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              load_mode_i,
    input  logic              ld_csb_i,
    input  logic              ld_web_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_din_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic              core_web_i,
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_din_o
);

    always_comb begin
        sram_csb_o  = 1'b1;
        sram_web_o  = 1'b1;
        sram_addr_o = '0;
        sram_din_o  = '0;
        if (load_mode_i) begin
            sram_csb_o  = ld_csb_i;
            sram_web_o  = ld_web_i;
            sram_addr_o = ld_addr_i;
            sram_din_o  = ld_din_i;
        end else begin
            // The core only fetches; its write data path is not wired here.
            sram_csb_o  = 1'b0;
            sram_web_o  = core_web_i;
            sram_addr_o = core_addr_i;
        end
    end

endmodule

// File: rtl/imem_wb_loader.sv
// Wishbone window that programs/reads the instruction SRAM and holds the core
// in reset and init mode until firmware releases it through CTRL.
module imem_wb_loader
    import imem_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic              core_web_i,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    input  logic [DATA_W-1:0] sram_dout0,
    output logic              core_init_en_o,
    output logic              core_reset_o
);

    localparam logic [7:0] WAIT_LAST = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;

    state_e            state_q;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic [1:0]        ctrl_q;
    logic              ctrl_pend_q;
    logic [1:0]        ctrl_wdat_q;
    logic [15:0]       count_q;
    logic              err_q;
    logic [7:0]        wait_q;
    logic              ld_csb_q;
    logic              ld_web_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [DATA_W-1:0] ld_din_q;

    logic        hit;
    logic [11:0] off;
    logic        is_mem;

    assign hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign off    = wbs_adr_i[11:0];
    assign is_mem = (off <= OFF_MEM_MAX);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            ctrl_q      <= 2'b11;
            ctrl_pend_q <= 1'b0;
            ctrl_wdat_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            ld_csb_q    <= 1'b1;
            ld_web_q    <= 1'b1;
            ld_addr_q   <= '0;
            ld_din_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        if (is_mem && !ctrl_q[CTRL_LOAD_BIT]) begin
                            ack_q   <= 1'b1;
                            dat_q   <= '0;
                            err_q   <= 1'b1;
                            state_q <= S_ACK;
                        end else if (is_mem && wbs_we_i && wbs_sel_i != 4'hF) begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_ACK;
                        end else if (is_mem) begin
                            ld_csb_q  <= 1'b0;
                            ld_web_q  <= !wbs_we_i;
                            ld_addr_q <= wbs_adr_i[ADDR_W+1:2];
                            if (wbs_we_i) begin
                                ld_din_q <= wbs_dat_i[DATA_W-1:0];
                            end
                            state_q <= wbs_we_i ? S_WR : S_RD_REQ;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= S_ACK;
                            // CTRL writes are applied on leaving ACK so ownership flips after the ack.
                            if (wbs_we_i && off == OFF_CTRL) begin
                                ctrl_pend_q <= 1'b1;
                                ctrl_wdat_q <= wbs_dat_i[1:0];
                            end else if (!wbs_we_i && off == OFF_CTRL) begin
                                dat_q <= {30'd0, ctrl_q};
                            end else if (!wbs_we_i && off == OFF_STATUS) begin
                                dat_q <= {15'd0, err_q, count_q};
                            end else begin
                                dat_q <= '0;
                            end
                        end
                    end
                end
                S_WR: begin
                    ld_csb_q <= 1'b1;
                    ld_web_q <= 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_q <= count_q + 16'd1;
                    end
                    if (wbs_cyc_i) begin
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    ld_csb_q <= 1'b1;
                    wait_q   <= '0;
                    if (!wbs_cyc_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= (RD_LAT > 1) ? S_RD_WAIT : S_RD_CAP;
                    end
                end
                S_RD_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state_q <= S_IDLE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_RD_CAP;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_RD_CAP: begin
                    if (!wbs_cyc_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        dat_q   <= 32'(sram_dout0);
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    dat_q   <= '0;
                    state_q <= S_IDLE;
                    if (ctrl_pend_q) begin
                        ctrl_q      <= ctrl_wdat_q;
                        ctrl_pend_q <= 1'b0;
                        count_q     <= '0;
                        err_q       <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;
    assign core_init_en_o = ctrl_q[CTRL_LOAD_BIT];
    assign core_reset_o   = ctrl_q[CTRL_RST_BIT];

    imem_sram_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .load_mode_i(ctrl_q[CTRL_LOAD_BIT]),
        .ld_csb_i   (ld_csb_q),
        .ld_web_i   (ld_web_q),
        .ld_addr_i  (ld_addr_q),
        .ld_din_i   (ld_din_q),
        .core_addr_i(core_addr_i),
        .core_web_i (core_web_i),
        .sram_csb_o (sram_csb0),
        .sram_web_o (sram_web0),
        .sram_addr_o(sram_addr0),
        .sram_din_o (sram_din0)
    );

endmodule

// File: tb/tb_imem_wb_loader.sv
// Directed bench for imem_wb_loader with a 2-cycle-latency SRAM model.
module tb_imem_wb_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int unsigned RDL  = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  core_addr_i;
    logic        core_web_i;
    logic        sram_csb0, sram_web0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;
    logic        core_init_en_o, core_reset_o;

    int checks = 0;
    int errors = 0;

    imem_wb_loader #(
        .BASE_ADDR(BASE),
        .ADDR_W(8),
        .DATA_W(32),
        .RD_LAT(RDL)
    ) dut (
        .CLK(CLK), .reset(reset),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_addr_i(core_addr_i), .core_web_i(core_web_i),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .core_init_en_o(core_init_en_o), .core_reset_o(core_reset_o)
    );

    always #5 CLK = ~CLK;

    // SRAM model: request captured at an edge, data on dout RDL edges later.
    logic [31:0] mem [256];
    logic [31:0] rd_stage;
    int          wr_ev = 0, rd_ev = 0;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rd_stage   = 32'h0;
        sram_dout0 = 32'h0;
    end

    always @(posedge CLK) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                mem[sram_addr0] <= sram_din0;
                if (core_init_en_o) begin
                    wr_ev   <= wr_ev + 1;
                    wr_addr <= sram_addr0;
                    wr_data <= sram_din0;
                end
            end else begin
                rd_stage <= mem[sram_addr0];
                if (core_init_en_o) begin
                    rd_ev   <= rd_ev + 1;
                    rd_addr <= sram_addr0;
                end
            end
        end
        sram_dout0 <= rd_stage;
    end

    // One bus transfer; lat = edges from request to visible ack, -1 if none within budget.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
        lat  = -1;
        rdat = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (wbs_ack_o) begin
                lat  = i;
                rdat = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_wb: ack=%b dat=%h expected 0/0", wbs_ack_o, wbs_dat_o); end
        checks++; if (core_init_en_o !== 1'b1 || core_reset_o !== 1'b1) begin errors++; $display("FAIL reset_core: init_en=%b rst=%b expected 1/1", core_init_en_o, core_reset_o); end
        checks++; if ({sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b1, 1'b1, 8'h0, 32'h0}) begin errors++; $display("FAIL reset_sram: csb=%b web=%b addr=%h din=%h expected 1/1/00/0", sram_csb0, sram_web0, sram_addr0, sram_din0); end
        reset = 1'b0;
        wb_xfer(1'b0, BASE + 32'h404, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL reset_status: lat=%0d dat=%h expected 1/00000000", lat, d); end
        checks++; if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL reset_idle_csb: got %b expected 1", sram_csb0); end
    endtask

    task automatic test_load();
        logic [31:0] d;
        int lat, ev0;
        ev0 = wr_ev;
        wb_xfer(1'b1, BASE + 32'h000, 32'h0000_0013, 4'hF, d, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load0_lat: got %0d expected 2", lat); end
        checks++; if (wr_ev - ev0 !== 1 || wr_addr !== 8'd0 || wr_data !== 32'h13) begin errors++; $display("FAIL load0_sram: writes=%0d addr=%h data=%h expected 1/00/00000013", wr_ev - ev0, wr_addr, wr_data); end
        ev0 = wr_ev;
        wb_xfer(1'b1, BASE + 32'h3FC, 32'hDEAD_BEEF, 4'hF, d, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load255_lat: got %0d expected 2", lat); end
        checks++; if (wr_ev - ev0 !== 1 || wr_addr !== 8'd255 || wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load255_sram: writes=%0d addr=%h data=%h expected 1/ff/deadbeef", wr_ev - ev0, wr_addr, wr_data); end
        wb_xfer(1'b0, BASE + 32'h404, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || d !== 32'h0000_0002) begin errors++; $display("FAIL load_status: lat=%0d dat=%h expected 1/00000002", lat, d); end
    endtask

    task automatic test_readback();
        logic [31:0] d;
        int lat, ev0;
        ev0 = rd_ev;
        wb_xfer(1'b0, BASE + 32'h3FC, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== RDL + 2 || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd255: lat=%0d dat=%h expected %0d/deadbeef", lat, d, RDL + 2); end
        checks++; if (rd_ev - ev0 !== 1 || rd_addr !== 8'd255) begin errors++; $display("FAIL rd255_req: reqs=%0d addr=%h expected 1/ff", rd_ev - ev0, rd_addr); end
        @(negedge CLK);
        checks++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rd_after_ack: ack=%b dat=%h expected 0/0", wbs_ack_o, wbs_dat_o); end
        wb_xfer(1'b0, BASE + 32'h000, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== RDL + 2 || d !== 32'h0000_0013) begin errors++; $display("FAIL rd0: lat=%0d dat=%h expected %0d/00000013", lat, d, RDL + 2); end
    endtask

    task automatic test_partial_and_release();
        logic [31:0] d;
        int lat, ev0;
        ev0 = wr_ev;
        wb_xfer(1'b1, BASE + 32'h008, 32'h1234_5678, 4'h3, d, lat);
        checks++; if (lat !== 1 || wr_ev - ev0 !== 0) begin errors++; $display("FAIL partial: lat=%0d writes=%0d expected 1/0", lat, wr_ev - ev0); end
        wb_xfer(1'b0, BASE + 32'h404, 32'h0, 4'hF, d, lat);
        checks++; if (d !== 32'h0001_0002) begin errors++; $display("FAIL partial_status: got %h expected 00010002", d); end
        core_addr_i = 8'h5A;
        wb_xfer(1'b1, BASE + 32'h400, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || core_init_en_o !== 1'b1) begin errors++; $display("FAIL ctrl_at_ack: lat=%0d init_en=%b expected 1/1", lat, core_init_en_o); end
        @(negedge CLK);
        checks++; if (core_init_en_o !== 1'b0 || core_reset_o !== 1'b0) begin errors++; $display("FAIL ctrl_release: init_en=%b rst=%b expected 0/0", core_init_en_o, core_reset_o); end
        checks++; if (sram_addr0 !== 8'h5A || sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_din0 !== 32'h0) begin errors++; $display("FAIL core_own: addr=%h csb=%b web=%b din=%h expected 5a/0/1/0", sram_addr0, sram_csb0, sram_web0, sram_din0); end
        wb_xfer(1'b0, BASE + 32'h404, 32'h0, 4'hF, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_clear_status: got %h expected 00000000", d); end
    endtask

    task automatic test_mem_when_core_owns();
        logic [31:0] d;
        int lat;
        wb_xfer(1'b0, BASE + 32'h010, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL lm0_read: lat=%0d dat=%h expected 1/0", lat, d); end
        wb_xfer(1'b0, BASE + 32'h404, 32'h0, 4'hF, d, lat);
        checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL lm0_err: got %h expected 00010000", d); end
        wb_xfer(1'b1, BASE + 32'h400, 32'h3, 4'hF, d, lat);
        @(negedge CLK);
        checks++; if (core_init_en_o !== 1'b1 || core_reset_o !== 1'b1 || sram_csb0 !== 1'b1) begin errors++; $display("FAIL reload: init_en=%b rst=%b csb=%b expected 1/1/1", core_init_en_o, core_reset_o, sram_csb0); end
    endtask

    task automatic test_other_offsets();
        logic [31:0] d;
        int lat;
        wb_xfer(1'b0, BASE + 32'h800, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL other_rd: lat=%0d dat=%h expected 1/0", lat, d); end
        wb_xfer(1'b1, BASE + 32'h408, 32'hFFFF_FFFF, 4'hF, d, lat);
        wb_xfer(1'b0, BASE + 32'h400, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || d !== 32'h3) begin errors++; $display("FAIL ctrl_rd: lat=%0d dat=%h expected 1/00000003", lat, d); end
        wb_xfer(1'b0, 32'h2000_0404, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== -1) begin errors++; $display("FAIL foreign_base: lat=%0d expected no ack (-1)", lat); end
    endtask

    task automatic test_abort_read();
        logic [31:0] d;
        int lat;
        logic seen;
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h3FC; wbs_sel_i = 4'hF;
        repeat (2) @(negedge CLK);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (wbs_ack_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_rd_ack: ack seen=%b expected 0", seen); end
        wb_xfer(1'b0, BASE + 32'h404, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL abort_rd_idle: lat=%0d dat=%h expected 1/0", lat, d); end
    endtask

    task automatic test_reset_during_write();
        logic [31:0] d;
        int lat;
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = BASE + 32'h004; wbs_dat_i = 32'h0000_0055; wbs_sel_i = 4'hF;
        @(negedge CLK);
        checks++; if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 8'd1) begin errors++; $display("FAIL wr_phase: csb=%b web=%b addr=%h expected 0/0/01", sram_csb0, sram_web0, sram_addr0); end
        reset = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge CLK);
        checks++; if (wbs_ack_o !== 1'b0 || {sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b1, 1'b1, 8'h0, 32'h0}) begin errors++; $display("FAIL rst_wr_outs: ack=%b csb=%b web=%b addr=%h din=%h expected 0/1/1/00/0", wbs_ack_o, sram_csb0, sram_web0, sram_addr0, sram_din0); end
        checks++; if (core_init_en_o !== 1'b1 || core_reset_o !== 1'b1) begin errors++; $display("FAIL rst_wr_core: init_en=%b rst=%b expected 1/1", core_init_en_o, core_reset_o); end
        reset = 1'b0;
        wb_xfer(1'b0, BASE + 32'h404, 32'h0, 4'hF, d, lat);
        checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL rst_wr_status: lat=%0d dat=%h expected 1/0", lat, d); end
    endtask

    initial begin
        reset = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        core_addr_i = 8'h00; core_web_i = 1'b1;
        test_reset();
        test_load();
        test_readback();
        test_partial_and_release();
        test_mem_when_core_owns();
        test_other_offsets();
        test_abort_read();
        test_reset_during_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
